// File: rtl/count_bits_seq.sv
// count_bits_seq: sequential bit-statistics unit.
// Takes one word over an in_valid/in_ready handshake. It walks the word
// BITS_PER_CYCLE bits per cycle and reports one of four statistics: ones,
// zeros, leading zeros or trailing zeros. The result is held under an
// out_valid/out_ready handshake.
//
// Handshake rule (both sides): a transfer happens on a posedge where valid
// and ready are both high. The sender holds valid and its payload until that
// edge. in_ready is high only in IDLE, and out_valid is high only in DONE.
// out_valid never depends combinationally on out_ready.
module count_bits_seq #(
  parameter int WORD_SIZE      = 16,
  parameter int BITS_PER_CYCLE = 1,
  parameter int COUNT_SIZE     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_SIZE-1:0]  data,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COUNT_SIZE-1:0] count,
  output logic                  busy
);

  localparam int NCHUNK = WORD_SIZE / BITS_PER_CYCLE;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam logic [COUNT_SIZE-1:0] B_C = COUNT_SIZE'(BITS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  logic [WORD_SIZE-1:0]    word;     // stored word, consumed from the LSB end
  logic [COUNT_SIZE-1:0]   acc;      // running result, drives count directly
  logic [CW-1:0]           chunks;   // chunks still to examine
  logic                    tz_path;  // 1: leading/trailing-zero modes, 0: popcount modes

  logic [BITS_PER_CYCLE-1:0] chunk;
  logic [COUNT_SIZE-1:0]     chunk_pop;
  logic [COUNT_SIZE-1:0]     chunk_low;
  logic                      chunk_any;
  logic [WORD_SIZE-1:0]      word_shift;
  logic [WORD_SIZE-1:0]      data_rev;
  logic [WORD_SIZE-1:0]      capture_word;

  assign count = acc;

  // Per-cycle chunk statistics: popcount, index of lowest set bit, next word.
  always_comb begin
    chunk      = word[BITS_PER_CYCLE-1:0];
    chunk_pop  = '0;
    chunk_low  = '0;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      chunk_pop = chunk_pop + COUNT_SIZE'(chunk[i]);
      if (chunk[i]) chunk_low = COUNT_SIZE'(i);
    end
    chunk_any  = |chunk;
    word_shift = word >> BITS_PER_CYCLE;
  end

  // Capture transform: zeros become ones, and leading zeros become trailing zeros.
  always_comb begin
    data_rev = '0;
    for (int i = 0; i < WORD_SIZE; i++) data_rev[i] = data[WORD_SIZE-1-i];
    case (mode)
      2'b01:   capture_word = ~data;
      2'b10:   capture_word = data_rev;
      default: capture_word = data;
    endcase
  end

  // Control FSM, datapath registers and registered handshake/status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      word      <= '0;
      acc       <= '0;
      chunks    <= '0;
      tz_path   <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word     <= capture_word;
            acc      <= '0;
            chunks   <= CW'(NCHUNK);
            tz_path  <= mode[1];
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          if (!tz_path) begin
            acc    <= acc + chunk_pop;
            word   <= word_shift;
            chunks <= chunks - 1'b1;
            // Once no ones remain above, the rest of the word adds nothing.
            if (word_shift == '0 || chunks == CW'(1)) begin
              state     <= DONE;
              busy      <= 1'b0;
              out_valid <= 1'b1;
            end
          end else if (chunk_any) begin
            acc       <= acc + chunk_low;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            acc    <= acc + B_C;
            word   <= word_shift;
            chunks <= chunks - 1'b1;
            if (chunks == CW'(1)) begin
              state     <= DONE;
              busy      <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_bits_seq.sv
// Testbench for count_bits_seq. Two instances, with 1 and 4 bits per cycle,
// share one producer and one consumer. A new word is offered only when both
// instances are idle. out_ready is raised only once both hold a result.
module tb_count_bits_seq;

  localparam int W = 16;
  localparam int C = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] data;
  logic [1:0]   mode;
  logic         out_ready;

  logic         in_ready_a, out_valid_a, busy_a;
  logic [C-1:0] count_a;
  logic         in_ready_b, out_valid_b, busy_b;
  logic [C-1:0] count_b;

  int n_checks = 0;
  int n_errors = 0;

  // Clock and DUTs
  always #5 clk = ~clk;

  count_bits_seq #(.WORD_SIZE(W), .BITS_PER_CYCLE(1), .COUNT_SIZE(C)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .data(data), .mode(mode), .out_valid(out_valid_a), .out_ready(out_ready),
    .count(count_a), .busy(busy_a)
  );

  count_bits_seq #(.WORD_SIZE(W), .BITS_PER_CYCLE(4), .COUNT_SIZE(C)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .data(data), .mode(mode), .out_valid(out_valid_b), .out_ready(out_ready),
    .count(count_b), .busy(busy_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: result from the statistic's definition. BUSY length
  // comes from the position of the interesting bit in the stored word.
  function automatic void model(input logic [W-1:0] d, input logic [1:0] m,
                                input int b, output int cnt, output int lat);
    logic [W-1:0] s;
    int h, t;
    case (m)
      2'b01: s = ~d;
      2'b10: for (int i = 0; i < W; i++) s[i] = d[W-1-i];
      default: s = d;
    endcase
    h = -1;
    t = W;
    for (int i = 0; i < W; i++) if (s[i]) h = i;
    for (int i = W - 1; i >= 0; i--) if (s[i]) t = i;
    cnt = 0;
    case (m)
      2'b00: cnt = $countones(d);
      2'b01: cnt = W - $countones(d);
      2'b10: for (int i = W - 1; i >= 0; i--) begin
               if (d[i]) break;
               cnt++;
             end
      default: for (int i = 0; i < W; i++) begin
                 if (d[i]) break;
                 cnt++;
               end
    endcase
    if (!m[1]) lat = (h < 0) ? 1 : (h + b) / b;
    else       lat = (t / b + 1 < W / b) ? t / b + 1 : W / b;
  endfunction

  task automatic wait_idle();
    int guard = 0;
    while (!(in_ready_a && in_ready_b) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("idle_wait", int'(guard < 100), 1);
  endtask

  // Drive one word. Garbage goes on data, mode and in_valid while both DUTs
  // are busy or holding. After hold extra cycles in DONE, release both.
  task automatic run_word(input logic [W-1:0] d, input logic [1:0] m, input int hold);
    int exp_a, lat_a, exp_b, lat_b, k;
    bit done_a, done_b;
    model(d, m, 1, exp_a, lat_a);
    model(d, m, 4, exp_b, lat_b);
    wait_idle();
    data = d; mode = m; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_a_start", busy_a, 1);
    check("busy_b_start", busy_b, 1);
    check("in_ready_a_busy", in_ready_a, 0);
    k = 0; done_a = 0; done_b = 0;
    while (!(done_a && done_b) && k < 200) begin
      data = W'($urandom); mode = 2'($urandom); in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      k++;
      @(negedge clk);
      if (!done_a && out_valid_a) begin
        done_a = 1;
        check("lat_a", k, lat_a);
        check("count_a", count_a, exp_a);
      end else if (done_a) begin
        check("hold_a", count_a, exp_a);
        check("hold_valid_a", out_valid_a, 1);
      end
      if (!done_b && out_valid_b) begin
        done_b = 1;
        check("lat_b", k, lat_b);
        check("count_b", count_b, exp_b);
      end else if (done_b) begin
        check("hold_b", count_b, exp_b);
      end
    end
    if (k >= 200) check("done_timeout", 0, 1);
    repeat (hold) begin
      data = W'($urandom); mode = 2'($urandom); in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check("stall_count_a", count_a, exp_a);
      check("stall_count_b", count_b, exp_b);
      check("stall_in_ready_a", in_ready_a, 0);
      check("stall_busy_b", busy_b, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid_a", out_valid_a, 0);
    check("release_ready_a", in_ready_a, 1);
    check("release_valid_b", out_valid_b, 0);
    check("release_ready_b", in_ready_b, 1);
  endtask

  // Stimulus
  initial begin
    logic [W-1:0] r;
    reset = 1'b1; in_valid = 1'b0; data = '0; mode = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready_a", in_ready_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_out_valid_a", out_valid_a, 0);
    check("rst_count_a", count_a, 0);
    check("rst_count_b", count_b, 0);

    run_word(16'h00F0, 2'b00, 0);
    run_word(16'h00F0, 2'b01, 0);
    run_word(16'h0000, 2'b00, 0);
    run_word(16'hFFFF, 2'b00, 0);
    run_word(16'h00F0, 2'b10, 0);
    run_word(16'h00F0, 2'b11, 0);
    run_word(16'h0000, 2'b11, 10);
    run_word(16'h0000, 2'b10, 0);
    run_word(16'h8000, 2'b11, 3);
    run_word(16'h0001, 2'b10, 0);

    // Reset during the third BUSY cycle discards the word.
    wait_idle();
    data = 16'hFFFF; mode = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_busy_a", busy_a, 1);
    check("mid_busy_b", busy_b, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_in_ready_a", in_ready_a, 1);
    check("midrst_busy_a", busy_a, 0);
    check("midrst_out_valid_a", out_valid_a, 0);
    check("midrst_count_a", count_a, 0);
    check("midrst_count_b", count_b, 0);
    check("midrst_in_ready_b", in_ready_b, 1);
    run_word(16'h0003, 2'b00, 0);

    for (int n = 0; n < 60; n++) begin
      r = W'($urandom);
      case ($urandom_range(0, 3))
        0: r = r;
        1: r = r >> $urandom_range(0, 15);
        2: r = r << $urandom_range(0, 15);
        default: r = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
      endcase
      run_word(r, 2'($urandom), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/count_bits_seq.md
# count_bits_seq

Parametrised sequential bit-statistics unit. It accepts a WORD_SIZE-bit word over a valid/ready handshake and examines it BITS_PER_CYCLE bits per clock. It reports one of four statistics: ones count, zeros count, leading-zero count or trailing-zero count. The result is held under a second valid/ready handshake. It is the multi-width, multi-mode successor of the team's 4-bit serial ones counter and sits between a data producer and any consumer that can stall.

## Interface
- WORD_SIZE, 16, input word width; must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1, bits examined per BUSY cycle; legal values 1, 2, 4, 8.
- COUNT_SIZE, 5, result width; must satisfy 2^COUNT_SIZE > WORD_SIZE.
- clk  input  1  clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers data and mode.
- in_ready  output  1  high only in IDLE.
- data  input  WORD_SIZE  word to analyse.
- mode  input  2  00 ones, 01 zeros, 10 leading zeros (from MSB), 11 trailing zeros (from LSB).
- out_valid  output  1  high only in DONE.
- out_ready  input  1  consumer accepts result.
- count  output  COUNT_SIZE  result; stable while out_valid is high.
- busy  output  1  high only in BUSY.

## Operation
- States: IDLE, BUSY, DONE. Encoding is free. in_ready, busy and out_valid decode directly from state.
- IDLE, in_valid=1: capture the word into a shift register, clear the accumulator, load the chunk counter with WORD_SIZE/BITS_PER_CYCLE, latch mode, go to BUSY.
- Capture transform:
  - Mode 01 stores ~data.
  - Mode 10 stores data bit-reversed.
  - Modes 00 and 11 store data unchanged.
- Modes 00/01 (popcount path): each BUSY cycle, add popcount of the low BITS_PER_CYCLE bits, shift right by BITS_PER_CYCLE and decrement the chunk counter. Exit to DONE when the shifted word is zero or the chunk counter reaches zero.
- Modes 10/11 (trailing-zero path): each BUSY cycle, take the low chunk.
  - If it holds a 1: add the index of its lowest 1, then go to DONE.
  - Otherwise: add BITS_PER_CYCLE, shift and decrement the chunk counter. Exit when the counter reaches zero.
  - An all-zero word yields count = WORD_SIZE.
- DONE: out_valid=1 and count is held. On out_ready=1, go to IDLE. in_ready rises on the following cycle; there is no same-cycle re-capture.
- data and mode are ignored outside the IDLE capture cycle. Changes during BUSY or DONE have no effect.
- The accumulator never overflows, because the maximum result is WORD_SIZE < 2^COUNT_SIZE.

## Timing
- Reset (any state, including mid-BUSY or DONE): next state IDLE. count=0, out_valid=0, busy=0, in_ready=1 after the edge. Any in-flight word is discarded.
- BUSY lasts at least 1 cycle.
  - Popcount path: max(1, ceil((h+1)/BITS_PER_CYCLE)) cycles, where h is the index of the highest 1 in the stored word. A zero word takes 1 cycle.
  - Trailing-zero path: min(floor(t/BITS_PER_CYCLE)+1, WORD_SIZE/BITS_PER_CYCLE) cycles, where t is the trailing-zero count of the stored word.
- Latency, capture edge to out_valid high = BUSY cycle count.
- A result held with out_ready=0 stays in DONE indefinitely, with count unchanged.
- in_valid=1 while in BUSY or DONE is not accepted. The producer must hold it until in_ready=1.

## Test plan
- WORD_SIZE=16, B=1, mode 00, data 16'h00F0 -> 8 BUSY cycles, count=4. With B=4 -> 2 BUSY cycles, count=4.
- B=1, mode 01, data 16'h00F0 -> 16 BUSY cycles, count=12. Mode 00, data 16'h0000 -> 1 BUSY cycle, count=0. Mode 00, data 16'hFFFF -> count=16.
- B=1, mode 10, data 16'h00F0 -> 9 BUSY cycles, count=8. Mode 11, same data -> 5 BUSY cycles, count=4.
- Mode 11, data 16'h0000 -> count=16: 16 BUSY cycles at B=1, 4 at B=4.
- Hold out_ready=0 for 10 cycles in DONE while toggling data, mode and in_valid -> count stable, in_ready=0. Then out_ready=1 -> IDLE, next word accepted one cycle later.
- Assert reset in the 3rd BUSY cycle of a mode 00 word 16'hFFFF -> next cycle IDLE, count=0, out_valid=0. A new word 16'h0003 then gives count=2.
